tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Periodic event scheduler for the vehicle control fabric. It divides the 50 MHz system clock into a 1 µs tick and runs NUM_CH programmable period counters on that tick. Due channels are shared over a single valid/ready event port with round-robin arbitration. Consumers such as sensor polling, PWM refresh and telemetry sequence their work from the emitted channel number instead of each running its own divider.

## Interface
- CLK_DIV, 50: clk cycles per tick; legal range 2..1024.
- NUM_CH, 4: number of scheduled channels; legal range 2..16.
- PERIOD_W, 16: width of each channel period, in ticks.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- enable  in  1  when high, prescaler and channel counters advance; when low, both hold.
- cfg_we  in  1  single-cycle period write strobe.
- cfg_ch  in  CH_W = clog2(NUM_CH)  channel addressed by cfg_we.
- cfg_period  in  PERIOD_W  new period in ticks; 0 disables the channel.
- tick  out  1  one-clk pulse on every CLK_DIV-th cycle while enable is high.
- fire_valid  out  1  at least one channel is pending.
- fire_ch  out  CH_W  channel being offered.
- fire_ready  in  1  consumer accepts the event.
- overrun  out  NUM_CH  sticky per-channel overrun flags.
- ovr_clr  in  1  clears all overrun flags.

## Operation
- **Prescaler:**
  - pre_cnt counts 0..CLK_DIV-1, advancing only when enable is high, and wraps to 0.
  - tick = enable & (pre_cnt == CLK_DIV-1). It is a combinational decode of a register and carries no glitch-sensitive logic.
- **Channel i counter:** updates on tick when period[i] != 0.
  - If ch_cnt[i] == period[i]-1: ch_cnt[i] <= 0 and pending[i] <= 1.
  - Otherwise: ch_cnt[i] <= ch_cnt[i]+1.
  - If period[i] == 0, ch_cnt[i] holds at 0 and pending[i] is never set.
- **cfg write:**
  - period[cfg_ch] <= cfg_period, ch_cnt[cfg_ch] <= 0, pending[cfg_ch] <= 0.
  - The write takes priority over a coincident tick for that channel.
- **Arbiter:**
  - fire_valid = |pending.
  - fire_ch is the first pending channel at or after rr_ptr, searching upward with wrap.
  - Once fire_valid is high and fire_ready is low, fire_ch is locked and must not change until accepted. This holds even if other channels become pending.
  - On acceptance (fire_valid & fire_ready): pending[fire_ch] <= 0 and rr_ptr <= fire_ch+1, wrapping to 0 after NUM_CH-1.
- **Simultaneous events:**
  - Acceptance of channel i coinciding with a new expiry of channel i leaves pending[i] = 1, with no overrun.
  - A cfg write to the locked channel clears pending and releases the lock.
- **enable low:** counters freeze; pending events still drain through the fire port.
- **Reset values:**
  - tick = 0, fire_valid = 0, fire_ch = 0, overrun = 0.
  - All period, ch_cnt, pending and rr_ptr registers are 0.
  - After reset every channel is disabled.

## Timing
- First tick occurs in clk cycle CLK_DIV after reset release, provided enable is held high.
- After a cfg write of period P to an idle channel, pending sets on the P-th subsequent tick. fire_valid is high in the next clk cycle.
- Event latency from expiry to fire_valid is 1 clk when the channel wins arbitration.
- Worst case an expired channel waits NUM_CH-1 acceptances.
- Accepted throughput is one event per clk.
- Reset asserted mid-handshake drops fire_valid immediately, since reset is asynchronous. All pending events are lost.

## Configuration
- **TICK_SCHED_OVERRUN_EN defined:**
  - overrun[i] sets when channel i expires while pending[i] is already 1 and not being accepted that cycle.
  - ovr_clr clears all flags. A set in the same cycle as ovr_clr wins.
- **TICK_SCHED_OVERRUN_EN undefined:**
  - overrun is tied to 0 and ovr_clr is ignored.
  - Repeated expiries coalesce silently into one pending event.

## Structure
- **Package tick_sched_pkg:**
  - Default constants for CLK_DIV, NUM_CH and PERIOD_W.
  - A ch_w(n) function returning clog2(n), minimum 1.
  - Typedef for the channel index.
- **Sub-module tick_prescaler:**
  - Ports: clk, reset, enable, tick.
  - Parameter: CLK_DIV.
- The channel counters, pending bits and round-robin arbiter stay in tick_scheduler.

## Test plan
- **Basic periodic fire:** CLK_DIV=50, ch0 period=10, fire_ready=1 → fire_valid pulses with fire_ch=0 every 500 clk. The first pulse comes 500 clk (+1 cycle pending latency) after the write.
- **Round-robin fairness:** ch0..ch3 all period=1, fire_ready=1 → fire_ch sequence 0,1,2,3 repeats; each channel fires once per tick; no overrun.
- **Backpressure lock:** ch1 and ch2 pending, fire_ready=0 for 200 clk → fire_ch stays 1 throughout. After ready, 1 then 2 are accepted.
- **Overrun (macro on):** ch3 period=2, fire_ready=0 for 4 ticks → overrun[3]=1 after the second expiry. ovr_clr → overrun=0; pending[3] is still 1.
- **Reconfigure and disable:** ch0 pending, cfg write ch0 period=0 → fire_valid drops next cycle with no event for ch0. enable low for 1000 clk → tick=0 and no new pending.
- **Async reset mid-operation:** reset pulse with fire_valid=1 → fire_valid, overrun and tick are 0 in the same cycle. All channels remain disabled afterwards.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
// tick_sched_pkg: shared constants and helpers for the tick scheduler slice.
//   CLK_DIV_DEF / NUM_CH_DEF / PERIOD_W_DEF : default build parameters
//   ch_w(n)                                 : channel index width, clog2(n) with a floor of 1
//   ch_idx_t                                : channel index for the default channel count
package tick_sched_pkg;

  localparam int CLK_DIV_DEF  = 50;  // 50 MHz -> 1 us tick
  localparam int NUM_CH_DEF   = 4;
  localparam int PERIOD_W_DEF = 16;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int CH_W_DEF = ch_w(NUM_CH_DEF);

  typedef logic [CH_W_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: valid/ready event port carrying the fired channel number.
//   fire_valid : scheduler has at least one pending channel
//   fire_ch    : channel being offered (stable while valid & !ready)
//   fire_ready : consumer accepts the offered event
// Modports: master = scheduler side, slave = consumer side.
interface tick_scheduler_if
  import tick_sched_pkg::*;
#(
  parameter int CH_W = CH_W_DEF
);
  logic            fire_valid;
  logic [CH_W-1:0] fire_ch;
  logic            fire_ready;

  modport master (output fire_valid, output fire_ch, input fire_ready);
  modport slave  (input fire_valid, input fire_ch, output fire_ready);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every CLK_DIV cycles.
//   clk, reset (async, active-high)
//   enable : counter advances only while high; tick is gated by it too
//   tick   : one-clk pulse when the counter sits on its last value
module tick_prescaler
  import tick_sched_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
)(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int             CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] pre_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pre_cnt <= '0;
    else if (enable) pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + 1'b1;
  end

  // Pure decode of a register plus enable: no extra state, one pulse per wrap.
  assign tick = enable & (pre_cnt == LAST);

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: NUM_CH programmable period counters running on a 1 us tick,
// with due channels shared over one round-robin valid/ready event port.
//   clk, reset (async, active-high)
//   enable              : advances prescaler and channel counters
//   cfg_we/cfg_ch/cfg_period : period write; period 0 disables the channel
//   tick                : prescaler pulse
//   fire (master)       : fire_valid / fire_ch / fire_ready event port
//   overrun, ovr_clr    : sticky per-channel overrun flags and their clear
// Optional feature: define TICK_SCHED_OVERRUN_EN to build the overrun flags;
// otherwise overrun is tied low and repeated expiries coalesce silently.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter  int CLK_DIV  = CLK_DIV_DEF,
  parameter  int NUM_CH   = NUM_CH_DEF,
  parameter  int PERIOD_W = PERIOD_W_DEF,
  localparam int CH_W     = ch_w(NUM_CH)
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [PERIOD_W-1:0]  cfg_period,
  output logic                 tick,
  tick_scheduler_if.master     fire,
  output logic [NUM_CH-1:0]    overrun,
  input  logic                 ovr_clr
);

  logic [NUM_CH-1:0][PERIOD_W-1:0] period_q, ch_cnt_q;
  logic [NUM_CH-1:0]               pending_q, expire, cfg_hit, accept_hit;
  logic [CH_W-1:0]                 rr_ptr_q, rr_pick, lock_ch_q;
  logic                            lock_q, accept;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // ---------------- arbiter ----------------
  // First pending channel at or after rr_ptr, wrapping.
  always_comb begin
    logic found;
    found   = 1'b0;
    rr_pick = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && pending_q[idx]) begin
        found   = 1'b1;
        rr_pick = CH_W'(idx);
      end
    end
  end

  assign fire.fire_valid = |pending_q;
  // Once offered and stalled, keep offering the same channel until it is taken.
  assign fire.fire_ch    = lock_q ? lock_ch_q : rr_pick;
  assign accept          = fire.fire_valid & fire.fire_ready;

  always_comb begin
    cfg_hit    = '0;
    expire     = '0;
    accept_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_hit[i]    = cfg_we & (cfg_ch == CH_W'(i));
      expire[i]     = tick & (period_q[i] != '0) & (ch_cnt_q[i] == period_q[i] - 1'b1);
      accept_hit[i] = accept & (fire.fire_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q <= (fire.fire_ch == CH_W'(NUM_CH - 1)) ? '0 : fire.fire_ch + 1'b1;
        lock_q   <= 1'b0;
      end else if (lock_q) begin
        // Reconfiguring the held channel wipes its event, so let go.
        if (cfg_we && cfg_ch == lock_ch_q) lock_q <= 1'b0;
      end else if (fire.fire_valid && !(cfg_we && cfg_ch == fire.fire_ch)) begin
        // Don't latch onto a channel whose pending bit is being cleared now.
        lock_q    <= 1'b1;
        lock_ch_q <= fire.fire_ch;
      end
    end
  end

  // ---------------- channel counters ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q  <= '0;
      ch_cnt_q  <= '0;
      pending_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_hit[i]) begin
          period_q[i]  <= cfg_period;
          ch_cnt_q[i]  <= '0;
          pending_q[i] <= 1'b0;
        end else begin
          if (tick && period_q[i] != '0)
            ch_cnt_q[i] <= expire[i] ? '0 : ch_cnt_q[i] + 1'b1;
          // A fresh expiry beats a coincident acceptance: the event re-arms.
          if (expire[i])          pending_q[i] <= 1'b1;
          else if (accept_hit[i]) pending_q[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- overrun ----------------
`ifdef TICK_SCHED_OVERRUN_EN
  logic [NUM_CH-1:0] ovr_q, ovr_set;

  assign ovr_set = expire & pending_q & ~accept_hit & ~cfg_hit;

  // Clear first, then OR in new sets so a coincident set survives the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr_q <= '0;
    else       ovr_q <= (ovr_clr ? '0 : ovr_q) | ovr_set;
  end

  assign overrun = ovr_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign overrun        = '0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler (CLK_DIV=50, NUM_CH=4, PERIOD_W=16).
// Inputs driven and outputs sampled 1 ns after the rising edge.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int CLK_DIV  = 50;
  localparam int NUM_CH   = 4;
  localparam int PERIOD_W = 16;
  localparam int CH_W     = ch_w(NUM_CH);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic                cfg_we = 1'b0;
  logic [CH_W-1:0]     cfg_ch = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic                ovr_clr = 1'b0;
  logic                tick;
  logic [NUM_CH-1:0]   overrun;

  tick_scheduler_if #(.CH_W(CH_W)) fif ();

  tick_scheduler #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .tick       (tick),
    .fire       (fif),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Write lands on the next rising edge; returns 1 ns after it.
  task automatic cfg(input int ch, input int p);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_period = PERIOD_W'(p);
    step();
    cfg_we = 1'b0;
  endtask

  // Returns when tick is high, i.e. the coming edge is a tick edge.
  task automatic wait_tick();
    int n = 0;
    do begin step(); n++; end while (!tick && n < 4*CLK_DIV);
    if (!tick) chk("tick_timeout", 0, 1);
  endtask

  // Counts edges until fire_valid is seen (0 if already high).
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!fif.fire_valid && n < limit) begin step(); n++; end
    if (!fif.fire_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  typedef struct {
    int ch;
    int period;
    int exp_edges;  // edges from the write edge to fire_valid
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n, bad, ticks;
    int seq_q[$];

    // write aligned to a tick edge: pending sets P*CLK_DIV edges later
    vecs[0] = '{0, 10, 500};
    vecs[1] = '{1,  1,  50};
    vecs[2] = '{2,  3, 150};
    vecs[3] = '{3,  7, 350};
    vecs[4] = '{1, 20, 1000};

    enable = 1'b1;
    fif.fire_ready = 1'b0;
    repeat (3) step();

    // ---- reset state ----
    chk("rst_tick",    tick, 0);
    chk("rst_valid",   fif.fire_valid, 0);
    chk("rst_fire_ch", fif.fire_ch, 0);
    chk("rst_overrun", overrun, 0);

    // ---- first tick: pre_cnt reaches CLK_DIV-1 after CLK_DIV-1 edges ----
    reset = 1'b0;
    n = 0;
    while (!tick && n < 2*CLK_DIV) begin step(); n++; end
    chk("first_tick_edges", n, CLK_DIV - 1);

    // ---- table: period write -> first fire latency and channel ----
    for (int v = 0; v < 5; v++) begin
      wait_tick();
      cfg(vecs[v].ch, vecs[v].period);
      wait_valid(vecs[v].exp_edges + 10, n);
      chk($sformatf("latency_v%0d", v), n, vecs[v].exp_edges);
      chk($sformatf("fire_ch_v%0d", v), fif.fire_ch, vecs[v].ch);
      cfg(vecs[v].ch, 0);
      chk($sformatf("disable_drop_v%0d", v), fif.fire_valid, 0);
    end

    // ---- basic periodic fire, ready held high ----
    fif.fire_ready = 1'b1;
    wait_tick();
    cfg(0, 10);
    wait_valid(600, n);
    chk("periodic_first", n, 500);
    step();
    chk("periodic_pulse_width", fif.fire_valid, 0);
    wait_valid(600, n);
    chk("periodic_interval", n + 1, 500);
    chk("periodic_ch", fif.fire_ch, 0);
    cfg(0, 0);

    // ---- round-robin fairness: all channels period 1 ----
    fif.fire_ready = 1'b0;
    pulse_reset();
    for (int c = 0; c < NUM_CH; c++) cfg(c, 1);
    fif.fire_ready = 1'b1;
    for (int k = 0; k < 220; k++) begin
      if (fif.fire_valid) seq_q.push_back(int'(fif.fire_ch));
      step();
    end
    chk("rr_event_count", seq_q.size(), 16);
    bad = 0;
    foreach (seq_q[k]) if (seq_q[k] != k % NUM_CH) bad++;
    chk("rr_order_errors", bad, 0);
    chk("rr_overrun", overrun, 0);

    // ---- backpressure lock ----
    fif.fire_ready = 1'b0;
    pulse_reset();
    cfg(1, 1);
    cfg(2, 1);
    cfg(0, 2);  // becomes pending mid-stall; must not steal the offer
    wait_valid(200, n);
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (!fif.fire_valid || fif.fire_ch != 2'd1) bad++;
      step();
    end
    chk("lock_hold_errors", bad, 0);
    fif.fire_ready = 1'b1;
    chk("lock_accept_1st", fif.fire_ch, 1);
    step();
    chk("lock_accept_2nd", fif.fire_ch, 2);
    step();
    chk("lock_accept_3rd", fif.fire_ch, 0);
    fif.fire_ready = 1'b0;

    // ---- overrun / coalescing: ch3 period 2, stalled 4 ticks ----
    pulse_reset();
    cfg(3, 2);
    repeat (4) wait_tick();
    step();
`ifdef TICK_SCHED_OVERRUN_EN
    chk("ovr_set", overrun, 4'b1000);
`else
    chk("ovr_tied_low", overrun, 0);
`endif
    chk("ovr_valid", fif.fire_valid, 1);
    chk("ovr_ch", fif.fire_ch, 3);
    ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_pending_kept", fif.fire_valid, 1);
    fif.fire_ready = 1'b1; step(); fif.fire_ready = 1'b0;
    chk("coalesced_single_event", fif.fire_valid, 0);

    // ---- acceptance coinciding with a new expiry ----
    pulse_reset();
    cfg(0, 1);
    wait_tick();
    step();
    chk("coinc_pending", fif.fire_valid, 1);
    wait_tick();
    fif.fire_ready = 1'b1; step(); fif.fire_ready = 1'b0;
    chk("coinc_rearmed", fif.fire_valid, 1);
    chk("coinc_no_overrun", overrun, 0);
    fif.fire_ready = 1'b1; step(); fif.fire_ready = 1'b0;
    chk("coinc_drained", fif.fire_valid, 0);

    // ---- reconfigure the locked channel ----
    wait_tick();
    step();
    step();  // stalled: ch0 now locked
    chk("recfg_valid_before", fif.fire_valid, 1);
    cfg(0, 0);
    chk("recfg_valid_drop", fif.fire_valid, 0);

    // ---- enable low: counters freeze, pending still drains ----
    cfg(1, 1);
    wait_valid(200, n);
    enable = 1'b0;
    cfg(2, 1);
    ticks = 0; bad = 0;
    for (int k = 0; k < 1000; k++) begin
      if (tick) ticks++;
      if (!fif.fire_valid || fif.fire_ch != 2'd1) bad++;
      step();
    end
    chk("en_low_ticks", ticks, 0);
    chk("en_low_offer_errors", bad, 0);
    fif.fire_ready = 1'b1; step(); fif.fire_ready = 1'b0;
    chk("en_low_drain_no_new", fif.fire_valid, 0);
    enable = 1'b1;

    // ---- async reset mid-handshake ----
    wait_valid(200, n);
    chk("arst_valid_before", fif.fire_valid, 1);
    #5 reset = 1'b1;
    #1;
    chk("arst_valid", fif.fire_valid, 0);
    chk("arst_tick", tick, 0);
    chk("arst_overrun", overrun, 0);
    step();
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      if (fif.fire_valid) bad++;
      step();
    end
    chk("arst_all_disabled", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
